// File: rtl/vec_issue_ctrl.sv
// In-order vector issue controller: operand FIFO, head classification, single-outstanding dispatch.
// Optional WAIT watchdog is built only when VEC_ISSUE_TIMEOUT_EN is defined.
module vec_issue_ctrl #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned QDEPTH  = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inst_valid,
   output logic            inst_ready,
   input  logic [XLEN-1:0] inst_data,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] issue_inst,
   output logic [XLEN-1:0] issue_rs1,
   output logic [XLEN-1:0] issue_rs2,
   output logic            vl_sel,
   output logic            vtype_sel,
   output logic            lumop_sel,
   output logic            csr_valid,
   output logic            lsu_valid,
   output logic            alu_valid,
   input  logic            csr_done,
   input  logic            lsu_done,
   input  logic            alu_done,
   output logic            illegal,
   output logic            busy,
   output logic            timeout_err
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   typedef enum logic [1:0] {T_CSR, T_LSU, T_ALU} tgt_t;

   state_t           state_q, state_d;
   tgt_t             tgt_q, dec_tgt;
   entry_t           mem [QDEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full, push, pop;
   logic             dec_legal, dec_vl, dec_vtype, dec_lumop;
   logic             unit_done;
   logic             csr_d, lsu_d, alu_d, illegal_d;

   assign full       = (count == CNT_W'(QDEPTH));
   assign inst_ready = !reset && !full;
   assign push       = inst_valid && inst_ready;
   assign head       = mem[rd_ptr];
   assign busy       = (state_q != S_IDLE) || (count != '0);

   // Operand FIFO; occupancy only moves when exactly one of push/pop fires
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{inst: inst_data, rs1: rs1_data, rs2: rs2_data};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (!push && pop) count <= count - CNT_W'(1);
      end
   end

   // Classify the FIFO head and derive the decoder operand selects
   always_comb begin
      dec_legal = 1'b0;
      dec_tgt   = T_ALU;
      dec_vl    = 1'b0;
      dec_vtype = 1'b0;
      dec_lumop = 1'b0;
      case (head.inst[6:0])
         7'h57: begin
            dec_legal = 1'b1;
            if (head.inst[14:12] == 3'b111) begin
               dec_tgt = T_CSR;
               if (!head.inst[31]) begin
                  dec_vtype = 1'b1;
               end else if (head.inst[30]) begin
                  dec_vl    = 1'b1;
                  dec_vtype = 1'b1;
               end
            end
         end
         7'h07, 7'h27: begin
            dec_legal = 1'b1;
            dec_tgt   = T_LSU;
            dec_lumop = (head.inst[27:26] == 2'b00);
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      case (tgt_q)
         T_CSR:   unit_done = csr_done;
         T_LSU:   unit_done = lsu_done;
         default: unit_done = alu_done;
      endcase
   end

`ifdef VEC_ISSUE_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [TO_W-1:0] wcnt_q, wcnt_d;
   logic            timeout_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and registered-output intents
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      csr_d     = 1'b0;
      lsu_d     = 1'b0;
      alu_d     = 1'b0;
      illegal_d = 1'b0;
`ifdef VEC_ISSUE_TIMEOUT_EN
      wcnt_d    = wcnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (count != '0) begin
               pop = 1'b1;
               if (dec_legal) state_d   = S_ISSUE;
               else           illegal_d = 1'b1;
            end
         end
         S_ISSUE: begin
            case (tgt_q)
               T_CSR:   csr_d = 1'b1;
               T_LSU:   lsu_d = 1'b1;
               default: alu_d = 1'b1;
            endcase
            state_d = S_WAIT;
`ifdef VEC_ISSUE_TIMEOUT_EN
            wcnt_d  = '0;
`endif
         end
         S_WAIT: begin
            if (unit_done) begin
               state_d = S_IDLE;
            end
`ifdef VEC_ISSUE_TIMEOUT_EN
            else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + TO_W'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Issue registers hold from one legal pop to the next
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_inst <= '0;
         issue_rs1  <= '0;
         issue_rs2  <= '0;
         vl_sel     <= 1'b0;
         vtype_sel  <= 1'b0;
         lumop_sel  <= 1'b0;
         tgt_q      <= T_CSR;
         csr_valid  <= 1'b0;
         lsu_valid  <= 1'b0;
         alu_valid  <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         csr_valid <= csr_d;
         lsu_valid <= lsu_d;
         alu_valid <= alu_d;
         illegal   <= illegal_d;
         if (pop && dec_legal) begin
            issue_inst <= head.inst;
            issue_rs1  <= head.rs1;
            issue_rs2  <= head.rs2;
            vl_sel     <= dec_vl;
            vtype_sel  <= dec_vtype;
            lumop_sel  <= dec_lumop;
            tgt_q      <= dec_tgt;
         end
      end
   end

`ifdef VEC_ISSUE_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wcnt_q      <= wcnt_d;
         timeout_err <= timeout_d;
      end
   end
`else
   // No watchdog: TIMEOUT is accepted for a uniform interface but has no effect
   assign timeout_err = 1'b0 && (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: directed cases plus randomized traffic against a decode-rule model.
module tb_vec_issue_ctrl;

   localparam int K_CSR = 0;
   localparam int K_LSU = 1;
   localparam int K_ALU = 2;
   localparam int K_ILL = 3;
   localparam logic [31:0] VADD = 32'h02000057;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] rs1;
      logic [31:0] rs2;
      int          kind;
      bit          vl;
      bit          vtype;
      bit          lumop;
   } exp_t;

   logic        clk, reset;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data, rs1_data, rs2_data;
   logic [31:0] issue_inst, issue_rs1, issue_rs2;
   logic        vl_sel, vtype_sel, lumop_sel;
   logic        csr_valid, lsu_valid, alu_valid;
   logic        csr_done, lsu_done, alu_done;
   logic        illegal, busy, timeout_err;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_acc = 0;
   bit          hold_done = 0;
   logic [31:0] last_legal = '0;
   exp_t        exp_q[$];

   vec_issue_ctrl #(.XLEN(32), .QDEPTH(4), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .issue_inst(issue_inst), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .vl_sel(vl_sel), .vtype_sel(vtype_sel), .lumop_sel(lumop_sel),
      .csr_valid(csr_valid), .lsu_valid(lsu_valid), .alu_valid(alu_valid),
      .csr_done(csr_done), .lsu_done(lsu_done), .alu_done(alu_done),
      .illegal(illegal), .busy(busy), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference decode written straight from the instruction-class rules
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
      exp_t        e;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [1:0]  top;
      op = w[6:0];
      f3 = w[14:12];
      top = w[31:30];
      e.inst = w; e.rs1 = r1; e.rs2 = r2;
      e.vl = 0; e.vtype = 0; e.lumop = 0;
      if (op == 7'h57 && f3 == 3'd7) begin
         e.kind  = K_CSR;
         e.vl    = (top == 2'b11);
         e.vtype = (top != 2'b10);
      end else if (op == 7'h57) begin
         e.kind = K_ALU;
      end else if (op == 7'h07 || op == 7'h27) begin
         e.kind  = K_LSU;
         e.lumop = (w[27:26] == 2'b00);
      end else begin
         e.kind = K_ILL;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
      int n;
      bit acc;
      bit done;
      n = 0;
      done = 0;
      inst_valid = 1'b1; inst_data = w; rs1_data = r1; rs2_data = r2;
      while (!done) begin
         @(negedge clk);
         acc = inst_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            exp_q.push_back(model(w, r1, r2));
            last_acc = cyc;
            done = 1;
         end else if (++n > 500) begin
            checks++; failures++;
            $display("FAIL push_timeout got=never_accepted want=accept inst=%h", w);
            done = 1;
         end
      end
      inst_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || exp_q.size() != 0) && n < bound);
      chk("drain_busy", 32'(busy), 32'd0);
      chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   // Monitor: every dispatch or illegal pulse pops one expectation
   initial begin : monitor
      int   nv, kind;
      bit   vprev;
      exp_t e;
      vprev = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            vprev = 0;
         end else begin
            nv = int'(csr_valid) + int'(lsu_valid) + int'(alu_valid) + int'(illegal);
            if (nv > 0) begin
               chk("one_event", 32'(nv), 32'd1);
               kind = csr_valid ? K_CSR : lsu_valid ? K_LSU : alu_valid ? K_ALU : K_ILL;
`ifndef VEC_ISSUE_TIMEOUT_EN
               chk("no_timeout", 32'(timeout_err), 32'd0);
`endif
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_event got=kind%0d want=nothing (cycle %0d)", kind, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("kind", 32'(kind), 32'(e.kind));
                  if (e.kind != K_ILL) begin
                     chk("issue_inst", issue_inst, e.inst);
                     chk("issue_rs1", issue_rs1, e.rs1);
                     chk("issue_rs2", issue_rs2, e.rs2);
                     chk("vl_sel", 32'(vl_sel), 32'(e.vl));
                     chk("vtype_sel", 32'(vtype_sel), 32'(e.vtype));
                     chk("lumop_sel", 32'(lumop_sel), 32'(e.lumop));
                     last_legal = e.inst;
                  end else begin
                     chk("illegal_keeps_inst", issue_inst, last_legal);
                  end
               end
            end
            if (csr_valid || lsu_valid || alu_valid) chk("valid_one_cycle", 32'(vprev), 32'd0);
            vprev = csr_valid || lsu_valid || alu_valid;
         end
      end
   end

   // Unit model: completes after 1..4 cycles, meanwhile raising the other units' done
   initial begin : responder
      bit pending;
      int tgt, cnt;
      pending = 0; tgt = 0; cnt = 0;
      csr_done = 0; lsu_done = 0; alu_done = 0;
      forever begin
         @(posedge clk);
         #2;
         csr_done = 0; lsu_done = 0; alu_done = 0;
         if (reset) begin
            pending = 0;
         end else begin
            if (csr_valid || lsu_valid || alu_valid) begin
               chk("no_early_issue", 32'(pending), 32'd0);
               pending = 1;
               tgt = csr_valid ? K_CSR : lsu_valid ? K_LSU : K_ALU;
               cnt = $urandom_range(1, 4);
            end
            if (pending && !hold_done && cnt == 0) begin
               csr_done = (tgt == K_CSR);
               lsu_done = (tgt == K_LSU);
               alu_done = (tgt == K_ALU);
               pending = 0;
            end else if (pending) begin
               if (cnt > 0) cnt--;
               csr_done = (tgt != K_CSR);
               lsu_done = (tgt != K_LSU);
               alu_done = (tgt != K_ALU);
            end else begin
               csr_done = ($urandom_range(0, 3) == 0);
               lsu_done = ($urandom_range(0, 3) == 0);
               alu_done = ($urandom_range(0, 3) == 0);
            end
         end
      end
   end

   initial begin : stimulus
      int          n;
      int          cls;
      logic [31:0] w;
      inst_valid = 0; inst_data = '0; rs1_data = '0; rs2_data = '0;
      reset = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_ready", 32'(inst_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_issue_inst", issue_inst, 32'd0);
      chk("reset_events", 32'({csr_valid, lsu_valid, alu_valid, illegal, timeout_err}), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(inst_ready), 32'd1);
      tick();

      // vsetvli dispatch latency from the accepting edge
      push(32'h01057057, 32'd8, 32'h55);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!csr_valid && n < 10);
      chk("vset_latency", 32'(cyc - last_acc), 32'd2);
      wait_idle(50);

      push(32'hC1047057, $urandom, $urandom);
      push(32'h80B57057, $urandom, $urandom);
      wait_idle(50);

      push(32'h02056087, $urandom, $urandom);
      push(32'h0A056087, $urandom, $urandom);
      wait_idle(50);

      // Back-pressure: one in flight plus a full FIFO
      hold_done = 1;
      for (int i = 0; i < 5; i++) push(VADD, 32'(i), ~32'(i));
      @(negedge clk);
      chk("full_after_5", 32'(inst_ready), 32'd0);
      repeat (4) @(negedge clk);
      chk("full_while_held", 32'(inst_ready), 32'd0);
      hold_done = 0;
      push(VADD, 32'd5, ~32'd5);
      wait_idle(100);

      push(VADD, 32'h11, 32'h22);
      push(32'h00000013, 32'h33, 32'h44);
      push(VADD, 32'h55, 32'h66);
      wait_idle(50);

      // Reset while waiting with three entries queued
      hold_done = 1;
      for (int i = 0; i < 4; i++) push(VADD, 32'h100 + 32'(i), 32'h200);
      repeat (3) @(negedge clk);
      tick();
      reset = 1'b1;
      exp_q.delete();
      last_legal = '0;
      tick();
      reset = 1'b0;
      hold_done = 0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valids", 32'({csr_valid, lsu_valid, alu_valid}), 32'd0);
      chk("abort_ready", 32'(inst_ready), 32'd1);
      repeat (6) @(negedge clk);
      chk("abort_no_replay", 32'(busy), 32'd0);
      tick();

`ifdef VEC_ISSUE_TIMEOUT_EN
      hold_done = 1;
      push(VADD, 32'h77, 32'h88);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!alu_valid && n < 10);
      last_acc = cyc;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!timeout_err && n < 300);
      chk("timeout_latency", 32'(cyc - last_acc), 32'd255);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hold_done = 0;
      tick();
`endif

      // Randomized mix of every instruction class
      for (int k = 0; k < 200; k++) begin
         cls = $urandom_range(0, 6);
         w = $urandom;
         case (cls)
            0: begin w[6:0] = 7'h57; w[14:12] = 3'd7; w[31] = 1'b0; end
            1: begin w[6:0] = 7'h57; w[14:12] = 3'd7; w[31:30] = 2'b11; end
            2: begin w[6:0] = 7'h57; w[14:12] = 3'd7; w[31:30] = 2'b10; end
            3: begin w[6:0] = 7'h57; w[14:12] = 3'($urandom_range(0, 6)); end
            4: begin w[6:0] = 7'h07; if ($urandom_range(0, 1) == 0) w[27:26] = 2'b00; end
            5: begin w[6:0] = 7'h27; if ($urandom_range(0, 1) == 0) w[27:26] = 2'b00; end
            default: while (w[6:0] == 7'h57 || w[6:0] == 7'h07 || w[6:0] == 7'h27) w[6:0] = 7'($urandom);
         endcase
         push(w, $urandom, $urandom);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) tick();
      end
      wait_idle(500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
